// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read master between icache (0) and dcache (1), one whole burst at a time.
// AR issues one cycle after a request is seen in IDLE; backpressure passes straight through in both directions.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_arvalid,
  input  logic [ADDR_WIDTH-1:0] ic_araddr,
  input  logic [7:0]            ic_arlen,
  input  logic [2:0]            ic_arsize,
  input  logic [1:0]            ic_arburst,
  output logic                  ic_arready,
  output logic                  ic_rvalid,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic                  ic_rlast,
  input  logic                  ic_rready,
  input  logic                  dc_arvalid,
  input  logic [ADDR_WIDTH-1:0] dc_araddr,
  input  logic [7:0]            dc_arlen,
  input  logic [2:0]            dc_arsize,
  input  logic [1:0]            dc_arburst,
  output logic                  dc_arready,
  output logic                  dc_rvalid,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_rlast,
  input  logic                  dc_rready,
  output logic                  m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,
  output logic                  m_axi_rready,
  output logic                  instruction_cache_reading,
  output logic                  data_cache_reading,
  output logic                  burst_len_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant;
  logic        w_grant_nxt;
  logic        r_last_grant;
  logic        w_last_grant_nxt;
  logic [7:0]  r_beats_left;
  logic [7:0]  w_beats_left_nxt;
  logic        r_burst_len_err;
  logic        w_err_nxt;
  logic        w_g_rready;
  logic        w_r_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_grant         <= 1'b0;
      r_last_grant    <= 1'b1;
      r_beats_left    <= 8'd0;
      r_burst_len_err <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_grant         <= w_grant_nxt;
      r_last_grant    <= w_last_grant_nxt;
      r_beats_left    <= w_beats_left_nxt;
      r_burst_len_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_beats_left_nxt = r_beats_left;
    w_err_nxt        = r_burst_len_err;
    w_g_rready       = r_grant ? dc_rready : ic_rready;
    w_r_fire         = 1'b0;
    ic_arready       = 1'b0;
    dc_arready       = 1'b0;
    ic_rvalid        = 1'b0;
    ic_rdata         = '0;
    ic_rlast         = 1'b0;
    dc_rvalid        = 1'b0;
    dc_rdata         = '0;
    dc_rlast         = 1'b0;
    m_axi_arvalid    = 1'b0;
    m_axi_araddr     = '0;
    m_axi_arlen      = 8'd0;
    m_axi_arsize     = 3'd0;
    m_axi_arburst    = 2'd0;
    m_axi_rready     = 1'b0;

    // Outputs are forced quiet while reset is held so the interconnect sees nothing mid-reset.
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (ic_arvalid || dc_arvalid) begin
            w_grant_nxt = (ic_arvalid && dc_arvalid) ? ~r_last_grant : dc_arvalid;
            w_state_nxt = ADDR;
          end
        end
        ADDR: begin
          m_axi_arvalid = 1'b1;
          m_axi_araddr  = r_grant ? dc_araddr  : ic_araddr;
          m_axi_arlen   = r_grant ? dc_arlen   : ic_arlen;
          m_axi_arsize  = r_grant ? dc_arsize  : ic_arsize;
          m_axi_arburst = r_grant ? dc_arburst : ic_arburst;
          ic_arready    = ~r_grant & m_axi_arready;
          dc_arready    = r_grant & m_axi_arready;
          if (m_axi_arready) begin
            w_beats_left_nxt = r_grant ? dc_arlen : ic_arlen;
            w_state_nxt      = DATA;
          end
        end
        DATA: begin
          m_axi_rready = w_g_rready;
          if (r_grant) begin
            dc_rvalid = m_axi_rvalid;
            dc_rdata  = m_axi_rdata;
            dc_rlast  = m_axi_rlast;
          end else begin
            ic_rvalid = m_axi_rvalid;
            ic_rdata  = m_axi_rdata;
            ic_rlast  = m_axi_rlast;
          end
          w_r_fire = m_axi_rvalid & w_g_rready;
          if (w_r_fire) begin
            if (r_beats_left != 8'd0) begin
              w_beats_left_nxt = r_beats_left - 8'd1;
            end
            // Length mismatch is only flagged; the FSM still trusts rlast to end the burst.
            if (m_axi_rlast && (r_beats_left != 8'd0)) begin
              w_err_nxt = 1'b1;
            end
            if (!m_axi_rlast && (r_beats_left == 8'd0)) begin
              w_err_nxt = 1'b1;
            end
            if (m_axi_rlast) begin
              w_state_nxt      = IDLE;
              w_last_grant_nxt = r_grant;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign instruction_cache_reading = ~reset & (r_state != IDLE) & ~r_grant;
  assign data_cache_reading        = ~reset & (r_state != IDLE) & r_grant;
  assign burst_len_err             = ~reset & r_burst_len_err;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter against a request/burst level model of the arbitration rules.
module tb_axi_read_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_arvalid, dc_arvalid;
  logic [AW-1:0] ic_araddr, dc_araddr;
  logic [7:0]    ic_arlen, dc_arlen;
  logic [2:0]    ic_arsize, dc_arsize;
  logic [1:0]    ic_arburst, dc_arburst;
  logic          ic_arready, dc_arready;
  logic          ic_rvalid, dc_rvalid;
  logic [DW-1:0] ic_rdata, dc_rdata;
  logic          ic_rlast, dc_rlast;
  logic          ic_rready, dc_rready;
  logic          m_axi_arvalid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arready;
  logic          m_axi_rvalid;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rlast;
  logic          m_axi_rready;
  logic          instruction_cache_reading, data_cache_reading, burst_len_err;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .ic_arvalid(ic_arvalid), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen),
    .ic_arsize(ic_arsize), .ic_arburst(ic_arburst), .ic_arready(ic_arready),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_rlast(ic_rlast), .ic_rready(ic_rready),
    .dc_arvalid(dc_arvalid), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen),
    .dc_arsize(dc_arsize), .dc_arburst(dc_arburst), .dc_arready(dc_arready),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_rlast(dc_rlast), .dc_rready(dc_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready),
    .instruction_cache_reading(instruction_cache_reading),
    .data_cache_reading(data_cache_reading),
    .burst_len_err(burst_len_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending request per cache, who was served last, expected sticky error.
  logic        pend    [2];
  logic [63:0] p_addr  [2];
  logic [7:0]  p_len   [2];
  logic [2:0]  p_size  [2];
  logic [1:0]  p_burst [2];
  int          served_last;
  logic        exp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int r);
    pend[r]    = 1'b1;
    p_addr[r]  = {$urandom, $urandom};
    p_len[r]   = 8'($urandom_range(0, 7));
    p_size[r]  = 3'($urandom_range(0, 7));
    p_burst[r] = 2'($urandom_range(0, 3));
  endtask

  task automatic drive_reqs();
    ic_arvalid = pend[0]; ic_araddr = p_addr[0]; ic_arlen = p_len[0];
    ic_arsize  = p_size[0]; ic_arburst = p_burst[0];
    dc_arvalid = pend[1]; dc_araddr = p_addr[1]; dc_arlen = p_len[1];
    dc_arsize  = p_size[1]; dc_arburst = p_burst[1];
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_arvld"}, 64'(m_axi_arvalid), 64'(0));
    check({tag, "_araddr"}, m_axi_araddr, 64'(0));
    check({tag, "_rrdy"}, 64'(m_axi_rready), 64'(0));
    check({tag, "_arrdy"}, 64'({ic_arready, dc_arready}), 64'(0));
    check({tag, "_rvld"}, 64'({ic_rvalid, dc_rvalid, ic_rlast, dc_rlast}), 64'(0));
    check({tag, "_rdata"}, ic_rdata | dc_rdata, 64'(0));
    check({tag, "_flags"}, 64'({instruction_cache_reading, data_cache_reading}), 64'(0));
    check({tag, "_err"}, 64'(burst_len_err), 64'(exp_err));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_arvld"}, 64'(m_axi_arvalid), 64'(0));
    check({tag, "_arrdy"}, 64'({ic_arready, dc_arready}), 64'(0));
    check({tag, "_rvld"}, 64'({ic_rvalid, dc_rvalid}), 64'(0));
    check({tag, "_rrdy"}, 64'(m_axi_rready), 64'(0));
    check({tag, "_flags"}, 64'({instruction_cache_reading, data_cache_reading}), 64'(0));
    check({tag, "_err"}, 64'(burst_len_err), 64'(exp_err));
  endtask

  // One arbitration round starting in an IDLE cycle. last_at=0 ends the burst at the
  // correct beat; abort_after>0 stops after that many beats and leaves the DUT in DATA.
  task automatic run_round(input int stall, input int last_at, input int rr_mode,
                           input bit add_mid, input int abort_after);
    int  w;
    int  acc;
    int  tgt;
    int  cyc;
    bit  done;
    bit  rr;
    logic [7:0] len;
    drive_reqs();
    #1;
    check_idle("idle");
    if (!pend[0] && !pend[1]) begin
      step();
      return;
    end
    w = (pend[0] && pend[1]) ? (1 - served_last) : (pend[1] ? 1 : 0);
    len = p_len[w];
    step();
    for (int i = 0; i <= stall; i++) begin
      m_axi_arready = (i == stall);
      #1;
      check("ar_vld", 64'(m_axi_arvalid), 64'(1));
      check("ar_addr", m_axi_araddr, p_addr[w]);
      check("ar_len", 64'(m_axi_arlen), 64'(p_len[w]));
      check("ar_size", 64'(m_axi_arsize), 64'(p_size[w]));
      check("ar_burst", 64'(m_axi_arburst), 64'(p_burst[w]));
      check("win_arrdy", 64'((w == 1) ? dc_arready : ic_arready), 64'(i == stall));
      check("lose_arrdy", 64'((w == 1) ? ic_arready : dc_arready), 64'(0));
      check("addr_flags", 64'({instruction_cache_reading, data_cache_reading}),
            64'({w == 0, w == 1}));
      step();
    end
    m_axi_arready = 1'b0;
    pend[w] = 1'b0;
    if (add_mid && !pend[1 - w]) new_req(1 - w);
    drive_reqs();
    tgt  = (last_at != 0) ? last_at : int'(len) + 1;
    acc  = 0;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 300 && !(abort_after > 0 && acc == abort_after)) begin
      m_axi_rvalid = ($urandom_range(0, 3) != 0);
      m_axi_rdata  = {$urandom, $urandom};
      m_axi_rlast  = (acc + 1 == tgt);
      rr = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 1) ? 1'(cyc % 2) : 1'b1;
      if (w == 1) begin
        dc_rready = rr; ic_rready = 1'($urandom_range(0, 1));
      end else begin
        ic_rready = rr; dc_rready = 1'($urandom_range(0, 1));
      end
      #1;
      check("win_rvld", 64'((w == 1) ? dc_rvalid : ic_rvalid), 64'(m_axi_rvalid));
      check("win_rdata", (w == 1) ? dc_rdata : ic_rdata, m_axi_rdata);
      check("win_rlast", 64'((w == 1) ? dc_rlast : ic_rlast), 64'(m_axi_rlast));
      check("m_rrdy", 64'(m_axi_rready), 64'(rr));
      check("lose_r", 64'({(w == 1) ? ic_rvalid : dc_rvalid, (w == 1) ? ic_rlast : dc_rlast}),
            64'(0));
      check("lose_rdata", (w == 1) ? ic_rdata : dc_rdata, 64'(0));
      check("data_ar", 64'({m_axi_arvalid, ic_arready, dc_arready}), 64'(0));
      check("data_flags", 64'({instruction_cache_reading, data_cache_reading}),
            64'({w == 0, w == 1}));
      if (m_axi_rvalid && rr) begin
        acc++;
        if (m_axi_rlast) done = 1'b1;
      end
      step();
      cyc++;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    if (abort_after > 0) return;
    if (!done) check("data_timeout", 64'(0), 64'(1));
    if (tgt != int'(len) + 1) exp_err = 1'b1;
    served_last = w;
    check_idle("post");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_reqs();
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
    served_last = 1;
    exp_err = 1'b0;
    #1;
    check_zero("rst");
    step();
    reset = 1'b0;
    #1;
    check_zero("after_rst");
  endtask

  initial begin
    pend[0] = 1'b0; pend[1] = 1'b0;
    p_addr[0] = '0; p_addr[1] = '0; p_len[0] = '0; p_len[1] = '0;
    p_size[0] = '0; p_size[1] = '0; p_burst[0] = '0; p_burst[1] = '0;
    ic_rready = 1'b0; dc_rready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
    served_last = 1;
    exp_err = 1'b0;
    reset = 1'b1;
    drive_reqs();
    step();
    do_reset();

    // Single icache burst of 8 beats at 0x1000.
    new_req(0); p_addr[0] = 64'h1000; p_len[0] = 8'd7;
    run_round(0, 0, 2, 1'b0, 0);

    // Simultaneous requests from reset, then held requests alternate.
    do_reset();
    new_req(0); new_req(1);
    for (int k = 0; k < 6; k++) begin
      run_round(k % 2, 0, 0, 1'b0, 0);
      if (!pend[0]) new_req(0);
      if (!pend[1]) new_req(1);
    end
    run_round(0, 0, 0, 1'b0, 0);
    run_round(0, 0, 0, 1'b0, 0);

    // dcache burst with long AR stall and toggling rready.
    new_req(1); p_len[1] = 8'd3;
    run_round(5, 0, 1, 1'b0, 0);

    // Early rlast, a clean burst, then a missing rlast.
    new_req(0); p_len[0] = 8'd3;
    run_round(0, 2, 2, 1'b0, 0);
    new_req(1);
    run_round(1, 0, 0, 1'b0, 0);
    new_req(0); p_len[0] = 8'd3;
    run_round(0, 6, 2, 1'b0, 0);

    // dcache request arrives while icache is in DATA.
    new_req(0); p_len[0] = 8'd5;
    run_round(0, 0, 0, 1'b1, 0);
    run_round(0, 0, 0, 1'b0, 0);

    // Reset mid-burst after two beats, then a fresh request.
    new_req(0); p_len[0] = 8'd7;
    run_round(0, 0, 2, 1'b0, 2);
    do_reset();
    new_req(1);
    run_round(0, 0, 0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      if (!pend[0] && $urandom_range(0, 1) == 1) new_req(0);
      if (!pend[1] && $urandom_range(0, 1) == 1) new_req(1);
      run_round($urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : 0,
                0, 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
